// File: rtl/key_debounce_multi_if.sv
// Key conditioner signal bundle: raw pins in, debounced level and event pulses out.
interface key_debounce_multi_if #(
  parameter int N_KEYS = 6
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] key_repeat;
  logic              tick;

  modport master (
    output key_in,
    input  key_state, key_press, key_release, key_long, key_repeat, tick
  );

  modport slave (
    input  key_in,
    output key_state, key_press, key_release, key_long, key_repeat, tick
  );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop sync, shared sample tick, tick-based debounce,
// and a per-key press/long/repeat FSM producing registered one-cycle events.
//   state  | meaning
//   S_IDLE | key released (debounced)
//   S_HELD | pressed, counting ticks toward the long-press threshold
//   S_LONG | long press reached; emitting repeat pulses if enabled
module key_debounce_multi #(
  parameter int N_KEYS       = 6,
  parameter int SCAN_DIV     = 1000000,
  parameter int DEB_SAMPLES  = 3,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int ACTIVE_LOW   = 1
) (
  input logic                  clk,
  input logic                  rst,
  key_debounce_multi_if.slave  bus
);

  localparam int CW   = $clog2(SCAN_DIV);
  localparam int DW   = $clog2(DEB_SAMPLES + 1);
  localparam int HMAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_M1   = DW'(DEB_SAMPLES - 1);
  localparam logic [HW-1:0] LONG_M1  = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] REP_M1   = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  // Synchroniser reset value is the released pin level so reset exit never looks like a press.
  localparam logic [N_KEYS-1:0] REL_LVL = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

  logic [N_KEYS-1:0] sync1, sync2, raw_s;
  logic [CW-1:0]     div_cnt;
  logic              tick;

  logic [N_KEYS-1:0] lvl, press_ev, rel_ev, long_ev, rep_ev;
  logic [N_KEYS-1:0] lvl_nxt, press_nxt, rel_nxt, long_nxt, rep_nxt;
  logic [DW-1:0]     deb_cnt  [N_KEYS];
  logic [DW-1:0]     deb_nxt  [N_KEYS];
  logic [HW-1:0]     hold_cnt [N_KEYS];
  logic [HW-1:0]     hold_nxt [N_KEYS];
  state_t            state     [N_KEYS];
  state_t            state_nxt [N_KEYS];

  assign raw_s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign tick  = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= REL_LVL;
      sync2   <= REL_LVL;
      div_cnt <= '0;
    end else begin
      sync1   <= bus.key_in;
      sync2   <= sync1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  always_comb begin
    lvl_nxt   = lvl;
    press_nxt = '0;
    rel_nxt   = '0;
    long_nxt  = '0;
    rep_nxt   = '0;
    deb_nxt   = deb_cnt;
    hold_nxt  = hold_cnt;
    state_nxt = state;
    for (int k = 0; k < N_KEYS; k++) begin
      if (tick) begin
        if (raw_s[k] == lvl[k]) begin
          deb_nxt[k] = '0;
        end else if (deb_cnt[k] < DEB_M1) begin
          deb_nxt[k] = deb_cnt[k] + 1'b1;
        end else begin
          deb_nxt[k]   = '0;
          lvl_nxt[k]   = raw_s[k];
          press_nxt[k] = raw_s[k];
          rel_nxt[k]   = ~raw_s[k];
        end
      end
      // An accepted release outranks a long/repeat threshold on the same tick.
      case (state[k])
        S_IDLE: begin
          if (press_nxt[k]) begin
            state_nxt[k] = S_HELD;
            hold_nxt[k]  = '0;
          end
        end
        S_HELD: begin
          if (rel_nxt[k]) begin
            state_nxt[k] = S_IDLE;
            hold_nxt[k]  = '0;
          end else if (tick) begin
            if (hold_cnt[k] == LONG_M1) begin
              long_nxt[k]  = 1'b1;
              state_nxt[k] = S_LONG;
              hold_nxt[k]  = '0;
            end else begin
              hold_nxt[k] = hold_cnt[k] + 1'b1;
            end
          end
        end
        S_LONG: begin
          if (rel_nxt[k]) begin
            state_nxt[k] = S_IDLE;
            hold_nxt[k]  = '0;
          end else if (tick && (REPEAT_TICKS > 0)) begin
            if (hold_cnt[k] == REP_M1) begin
              rep_nxt[k]  = 1'b1;
              hold_nxt[k] = '0;
            end else begin
              hold_nxt[k] = hold_cnt[k] + 1'b1;
            end
          end
        end
        default: begin
          state_nxt[k] = S_IDLE;
          hold_nxt[k]  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl      <= '0;
      press_ev <= '0;
      rel_ev   <= '0;
      long_ev  <= '0;
      rep_ev   <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        deb_cnt[k]  <= '0;
        hold_cnt[k] <= '0;
        state[k]    <= S_IDLE;
      end
    end else begin
      lvl      <= lvl_nxt;
      press_ev <= press_nxt;
      rel_ev   <= rel_nxt;
      long_ev  <= long_nxt;
      rep_ev   <= rep_nxt;
      deb_cnt  <= deb_nxt;
      hold_cnt <= hold_nxt;
      state    <= state_nxt;
    end
  end

  assign bus.key_state   = lvl;
  assign bus.key_press   = press_ev;
  assign bus.key_release = rel_ev;
  assign bus.key_long    = long_ev;
  assign bus.key_repeat  = rep_ev;
  assign bus.tick        = tick;

endmodule
